// File: rtl/ptr_noc_pkg.sv
`default_nettype none
// ============================================================================
// ptr_noc_pkg : shared constants and hop-count helper for the ring NoC
// Rev 1.0 - initial release
// ============================================================================
package ptr_noc_pkg;

    localparam int STAT_W = 16;

    // Clockwise distance from nodeId to dest on a ring of nodeNum nodes
    function automatic int unsigned hopCount(
        input int unsigned dest,
        input int unsigned nodeNum,
        input int unsigned nodeId
    );
        return (dest + nodeNum - nodeId) % nodeNum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/PtrNocLocalIf.sv
`default_nettype none
// ============================================================================
// PtrNocLocalIf : router <-> local node port bundle
// Rev 1.0 - initial release
// ============================================================================
interface PtrNocLocalIf #(
    parameter int DATA_WIDTH = 32,
    parameter int NODE_NUM   = 8
);
    localparam int c_DW = $clog2(NODE_NUM);

    logic                  r2lPktVld;
    logic                  r2lRd;
    logic [DATA_WIDTH-1:0] r2lDat;
    logic                  l2rFul;
    logic                  l2rWr;
    logic [DATA_WIDTH-1:0] l2rDat;
    logic [c_DW-1:0]       destCnt;

    modport LocalNode (
        input  r2lPktVld, l2rFul, r2lDat,
        output r2lRd, l2rWr, l2rDat, destCnt
    );

    modport Router (
        output r2lPktVld, l2rFul, r2lDat,
        input  r2lRd, l2rWr, l2rDat, destCnt
    );
endinterface
`default_nettype wire

// File: rtl/TwoRegFifo.sv
`default_nettype none
// ============================================================================
// TwoRegFifo : two-entry register FIFO, head always presented on oDat
// Rev 1.0 - initial release
// ============================================================================
module TwoRegFifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iDat,
    input  logic             iPop,
    output logic             oFull,
    output logic             oVld,
    output logic [WIDTH-1:0] oDat
);
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_dat0;
    logic [WIDTH-1:0] r_dat1;
    logic             w_push;
    logic             w_pop;

    assign oFull  = (r_cnt == 2'd2);
    assign oVld   = (r_cnt != 2'd0);
    assign oDat   = r_dat0;
    assign w_pop  = iPop & oVld;
    assign w_push = iPush & ~oFull;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_dat0 <= '0;
            r_dat1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_dat0 <= iDat;
                    else               r_dat1 <= iDat;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_dat0 <= r_dat1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Push is blocked when full, so a simultaneous push/pop means one entry
                    r_dat0 <= iDat;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/ptr_local_ni.sv
`default_nettype none
// ============================================================================
// ptr_local_ni : local network interface between a source/sink and a ring router
// Rev 1.0 - initial release
// ============================================================================
module ptr_local_ni
    import ptr_noc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NODE_NUM   = 8,
    parameter int NODE_ID    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    PtrNocLocalIf.LocalNode             bLocalDat,
    input  logic                        iSrcVld,
    output logic                        oSrcRdy,
    input  logic [DATA_WIDTH-1:0]       iSrcDat,
    input  logic [$clog2(NODE_NUM)-1:0] iSrcDest,
    output logic                        oSnkVld,
    input  logic                        iSnkRdy,
    output logic [DATA_WIDTH-1:0]       oSnkDat,
    output logic                        oSnkLoop,
    output logic                        oErrDrop,
    input  logic                        iClrCnt,
    output logic [STAT_W-1:0]           oInjCnt,
    output logic [STAT_W-1:0]           oEjCnt
);
    localparam int c_DW = $clog2(NODE_NUM);
    localparam int c_FW = DATA_WIDTH + c_DW;

    logic                  r_run;
    logic                  r_snkVld;
    logic [DATA_WIDTH-1:0] r_snkDat;
    logic                  r_snkLoop;
    logic                  r_lastLoop;
    logic [STAT_W-1:0]     r_injCnt;
    logic [STAT_W-1:0]     r_ejCnt;

    logic                  w_fifoFull;
    logic                  w_headVld;
    logic [c_FW-1:0]       w_headWord;
    logic [DATA_WIDTH-1:0] w_headDat;
    logic [c_DW-1:0]       w_headDest;
    logic [c_DW-1:0]       w_hop;
    logic                  w_legal;
    logic                  w_lbReq;
    logic                  w_l2rWr;
    logic                  w_load;
    logic                  w_grantRtr;
    logic                  w_grantLb;
    logic                  w_pop;

    TwoRegFifo #(
        .WIDTH (c_FW)
    ) u_ingress (
        .clk   (clk),
        .rst   (rst),
        .iPush (iSrcVld & oSrcRdy),
        .iDat  ({iSrcDat, iSrcDest}),
        .iPop  (w_pop),
        .oFull (w_fifoFull),
        .oVld  (w_headVld),
        .oDat  (w_headWord)
    );

    assign w_headDat  = w_headWord[c_FW-1:c_DW];
    assign w_headDest = w_headWord[c_DW-1:0];
    assign w_hop      = c_DW'(hopCount(32'(w_headDest), NODE_NUM, NODE_ID));
    assign w_legal    = (int'(w_headDest) < NODE_NUM);
    assign w_lbReq    = w_headVld & w_legal & (w_hop == '0);
    assign w_l2rWr    = w_headVld & w_legal & (w_hop != '0) & ~bLocalDat.l2rFul;

    // r_run holds the datapath idle until the first clock after reset release
    assign oSrcRdy    = r_run & ~w_fifoFull;
    assign oErrDrop   = w_headVld & ~w_legal;

    // Round robin: r_lastLoop set means loopback won last, so router is favoured
    assign w_load     = r_run & (~r_snkVld | iSnkRdy);
    assign w_grantRtr = w_load & bLocalDat.r2lPktVld & (~w_lbReq | r_lastLoop);
    assign w_grantLb  = w_load & w_lbReq & (~bLocalDat.r2lPktVld | ~r_lastLoop);
    assign w_pop      = w_l2rWr | oErrDrop | w_grantLb;

    assign bLocalDat.l2rWr   = w_l2rWr;
    assign bLocalDat.l2rDat  = w_headDat;
    assign bLocalDat.destCnt = w_hop;
    assign bLocalDat.r2lRd   = w_grantRtr;

    assign oSnkVld  = r_snkVld;
    assign oSnkDat  = r_snkDat;
    assign oSnkLoop = r_snkLoop;
    assign oInjCnt  = r_injCnt;
    assign oEjCnt   = r_ejCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_snkVld   <= 1'b0;
            r_snkDat   <= '0;
            r_snkLoop  <= 1'b0;
            r_lastLoop <= 1'b1;
            r_injCnt   <= '0;
            r_ejCnt    <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_grantLb) begin
                r_snkVld   <= 1'b1;
                r_snkDat   <= w_headDat;
                r_snkLoop  <= 1'b1;
                r_lastLoop <= 1'b1;
            end else if (w_grantRtr) begin
                r_snkVld   <= 1'b1;
                r_snkDat   <= bLocalDat.r2lDat;
                r_snkLoop  <= 1'b0;
                r_lastLoop <= 1'b0;
            end else if (iSnkRdy) begin
                r_snkVld   <= 1'b0;
            end

            if (iClrCnt) r_injCnt <= '0;
            else if (w_l2rWr && r_injCnt != '1) r_injCnt <= r_injCnt + 1'b1;

            if (iClrCnt) r_ejCnt <= '0;
            else if (r_snkVld && iSnkRdy && r_ejCnt != '1) r_ejCnt <= r_ejCnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ptr_local_ni.sv
`default_nettype none
// ============================================================================
// tb_ptr_local_ni : randomized bench with queue-based reference model
// Rev 1.0 - initial release
// ============================================================================
module tb_ptr_local_ni;
    localparam int NN  = 8;
    localparam int NID = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iSrcVld = 1'b0, iSnkRdy = 1'b0, iClrCnt = 1'b0;
    logic [31:0] iSrcDat = '0;
    logic [2:0]  iSrcDest = '0;
    logic        oSrcRdy, oSnkVld, oSnkLoop, oErrDrop;
    logic [31:0] oSnkDat;
    logic [15:0] oInjCnt, oEjCnt;

    logic        s2Vld = 1'b0, s2SnkRdy = 1'b0, s2Clr = 1'b0;
    logic [31:0] s2Dat = '0;
    logic [2:0]  s2Dest = '0;
    logic        s2SrcRdy, s2SnkVld, s2SnkLoop, s2Err;
    logic [31:0] s2SnkDat;
    logic [15:0] s2Inj, s2Ej;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    PtrNocLocalIf #(.DATA_WIDTH(32), .NODE_NUM(8)) bus ();
    PtrNocLocalIf #(.DATA_WIDTH(32), .NODE_NUM(6)) bus2 ();

    ptr_local_ni #(.DATA_WIDTH(32), .NODE_NUM(NN), .NODE_ID(NID)) dut (
        .clk(clk), .rst(rst), .bLocalDat(bus),
        .iSrcVld(iSrcVld), .oSrcRdy(oSrcRdy), .iSrcDat(iSrcDat), .iSrcDest(iSrcDest),
        .oSnkVld(oSnkVld), .iSnkRdy(iSnkRdy), .oSnkDat(oSnkDat), .oSnkLoop(oSnkLoop),
        .oErrDrop(oErrDrop), .iClrCnt(iClrCnt), .oInjCnt(oInjCnt), .oEjCnt(oEjCnt)
    );

    ptr_local_ni #(.DATA_WIDTH(32), .NODE_NUM(6), .NODE_ID(1)) dut2 (
        .clk(clk), .rst(rst), .bLocalDat(bus2),
        .iSrcVld(s2Vld), .oSrcRdy(s2SrcRdy), .iSrcDat(s2Dat), .iSrcDest(s2Dest),
        .oSnkVld(s2SnkVld), .iSnkRdy(s2SnkRdy), .oSnkDat(s2SnkDat), .oSnkLoop(s2SnkLoop),
        .oErrDrop(s2Err), .iClrCnt(s2Clr), .oInjCnt(s2Inj), .oEjCnt(s2Ej)
    );

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] dat; logic [2:0] dest; } word_t;
    word_t mq[$];
    bit          mRun, mEgVld, mEgLoop, mLastLoop;
    logic [31:0] mEgDat;
    int          mInj, mEj;
    bit          eSrcRdy, eWr, eErr, eLb, eRd;
    word_t       hd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void mReset();
        mq.delete();
        mRun = 0; mEgVld = 0; mEgLoop = 0; mEgDat = '0; mLastLoop = 1; mInj = 0; mEj = 0;
    endfunction

    task automatic compareAll();
        int  hop;
        bit  headVld, legal, canLoad, lbReq;
        if (rst) mReset();
        headVld = (mq.size() > 0);
        hd      = headVld ? mq[0] : '0;
        legal   = (int'(hd.dest) < NN);
        hop     = (int'(hd.dest) + NN - NID) % NN;
        eSrcRdy = mRun && (mq.size() < 2);
        eWr     = headVld && legal && hop != 0 && !bus.l2rFul;
        eErr    = headVld && !legal;
        lbReq   = headVld && legal && hop == 0;
        canLoad = mRun && (!mEgVld || iSnkRdy);
        // Contested: the source that did not win last time gets the slot
        if (canLoad && lbReq && bus.r2lPktVld) begin
            eLb = !mLastLoop; eRd = mLastLoop;
        end else begin
            eLb = canLoad && lbReq; eRd = canLoad && bus.r2lPktVld;
        end
        chk("srcRdy", {31'd0, oSrcRdy}, {31'd0, eSrcRdy});
        chk("l2rWr", {31'd0, bus.l2rWr}, {31'd0, eWr});
        if (eWr) begin
            chk("l2rDat", bus.l2rDat, hd.dat);
            chk("destCnt", 32'(bus.destCnt), 32'(hop));
        end
        chk("r2lRd", {31'd0, bus.r2lRd}, {31'd0, eRd});
        chk("errDrop", {31'd0, oErrDrop}, {31'd0, eErr});
        chk("snkVld", {31'd0, oSnkVld}, {31'd0, mEgVld});
        if (mEgVld) begin
            chk("snkDat", oSnkDat, mEgDat);
            chk("snkLoop", {31'd0, oSnkLoop}, {31'd0, mEgLoop});
        end
        chk("injCnt", 32'(oInjCnt), 32'(mInj));
        chk("ejCnt", 32'(oEjCnt), 32'(mEj));
    endtask

    task automatic advance();
        bit hs;
        if (rst) begin
            mReset();
            return;
        end
        hs = mEgVld && iSnkRdy;
        if (eWr || eErr || eLb) void'(mq.pop_front());
        if (eLb) begin
            mEgVld = 1; mEgDat = hd.dat; mEgLoop = 1; mLastLoop = 1;
        end else if (eRd) begin
            mEgVld = 1; mEgDat = bus.r2lDat; mEgLoop = 0; mLastLoop = 0;
        end else if (hs) begin
            mEgVld = 0;
        end
        if (iClrCnt) begin
            mInj = 0; mEj = 0;
        end else begin
            if (eWr && mInj < 16'hFFFF) mInj++;
            if (hs && mEj < 16'hFFFF) mEj++;
        end
        if (iSrcVld && eSrcRdy) mq.push_back('{dat: iSrcDat, dest: iSrcDest});
        mRun = 1;
    endtask

    task automatic cycle();
        @(negedge clk);
        compareAll();
        @(posedge clk);
        advance();
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        mReset();
        bus.r2lPktVld = 1'b1; bus.r2lDat = 32'h0; bus.l2rFul = 1'b0;
        bus2.r2lPktVld = 1'b0; bus2.r2lDat = 32'h0; bus2.l2rFul = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_srcRdy", {31'd0, oSrcRdy}, 32'd0);
        chk("rst_r2lRd", {31'd0, bus.r2lRd}, 32'd0);
        chk("rst_snkVld", {31'd0, oSnkVld}, 32'd0);
        chk("rst_cnt", {oInjCnt, oEjCnt}, 32'd0);
        bus.r2lPktVld = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        chk("rel_srcRdy", {31'd0, oSrcRdy}, 32'd1);

        // Second node (6-node ring, id 1): illegal destination, wrap hop, loopback
        s2SnkRdy = 1'b1;
        s2Vld = 1'b1; s2Dat = 32'h77; s2Dest = 3'd7;
        cycle();
        s2Vld = 1'b0; #1;
        chk("n6_errDrop", {31'd0, s2Err}, 32'd1);
        chk("n6_errNoWr", {31'd0, bus2.l2rWr}, 32'd0);
        cycle(); #1;
        chk("n6_errPulse", {31'd0, s2Err}, 32'd0);
        chk("n6_errInj", 32'(s2Inj), 32'd0);
        s2Vld = 1'b1; s2Dat = 32'hD0; s2Dest = 3'd0;
        cycle();
        s2Vld = 1'b0; #1;
        chk("n6_wr", {31'd0, bus2.l2rWr}, 32'd1);
        chk("n6_destCnt", 32'(bus2.destCnt), 32'd5);
        chk("n6_l2rDat", bus2.l2rDat, 32'hD0);
        cycle(); #1;
        chk("n6_inj", 32'(s2Inj), 32'd1);
        s2Vld = 1'b1; s2Dat = 32'h11; s2Dest = 3'd1;
        cycle();
        s2Vld = 1'b0; #1;
        chk("n6_lbLat1", {31'd0, s2SnkVld}, 32'd0);
        cycle(); #1;
        chk("n6_lbVld", {30'd0, s2SnkVld, s2SnkLoop}, 32'd3);
        chk("n6_lbDat", s2SnkDat, 32'h11);
        chk("n6_r2lRd", {31'd0, bus2.r2lRd}, 32'd0);
        cycle(); #1;
        chk("n6_ej", 32'(s2Ej), 32'd1);
        chk("n6_srcRdy", {31'd0, s2SrcRdy}, 32'd1);

        // Injection to dest 7 from node 5
        iSnkRdy = 1'b1;
        iSrcVld = 1'b1; iSrcDat = 32'hA5A5_0001; iSrcDest = 3'd7;
        cycle();
        iSrcVld = 1'b0; #1;
        chk("inj_wr", {31'd0, bus.l2rWr}, 32'd1);
        chk("inj_destCnt", 32'(bus.destCnt), 32'd2);
        chk("inj_dat", bus.l2rDat, 32'hA5A5_0001);
        cycle(); #1;
        chk("inj_cnt", 32'(oInjCnt), 32'd1);

        iSrcVld = 1'b1; iSrcDat = 32'h0000_0222; iSrcDest = 3'd2;
        cycle();
        iSrcVld = 1'b0; #1;
        chk("wrap_destCnt", 32'(bus.destCnt), 32'd5);
        cycle();

        iSrcVld = 1'b1; iSrcDat = 32'h0000_0555; iSrcDest = 3'd5;
        cycle();
        iSrcVld = 1'b0; #1;
        chk("lb_noWr", {30'd0, bus.l2rWr, oSnkVld}, 32'd0);
        cycle(); #1;
        chk("lb_lat2", {30'd0, oSnkVld, oSnkLoop}, 32'd3);
        cycle();

        // Ring backpressure: three pushes, only two fit
        bus.l2rFul = 1'b1; iSrcVld = 1'b1; iSrcDest = 3'd6;
        for (int i = 0; i < 10; i++) begin
            iSrcDat = 32'h600 + 32'((i > 2) ? 2 : i);
            if (i == 2) begin
                #1 chk("bp_full", {30'd0, oSrcRdy, bus.l2rWr}, 32'd0);
            end
            cycle();
        end
        iSrcVld = 1'b0; bus.l2rFul = 1'b0; #1;
        chk("bp_rel0", {bus.l2rWr, bus.l2rDat[30:0]}, 32'h8000_0600);
        cycle(); #1;
        chk("bp_rel1", {bus.l2rWr, bus.l2rDat[30:0]}, 32'h8000_0601);
        cycle(); #1;
        chk("bp_done", {31'd0, bus.l2rWr}, 32'd0);
        cycle();

        // Contested egress alternates router / loopback
        iSrcVld = 1'b1; iSrcDest = 3'd5; bus.r2lPktVld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            iSrcDat = 32'hC000 + 32'(i); bus.r2lDat = 32'hB000 + 32'(i);
            #1 chk("rr_r2lRd", {31'd0, bus.r2lRd}, (i % 2 == 0) ? 32'd1 : 32'd0);
            cycle();
        end
        iSnkRdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("stall_r2lRd", {31'd0, bus.r2lRd}, 32'd0);
            cycle();
        end
        iSnkRdy = 1'b1; iSrcVld = 1'b0; bus.r2lPktVld = 1'b0;
        repeat (4) cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            iSrcVld       = 1'($urandom % 2);
            iSrcDat       = $urandom;
            iSrcDest      = 3'($urandom_range(7, 0));
            bus.l2rFul    = ($urandom % 4) == 0;
            bus.r2lPktVld = 1'($urandom % 2);
            bus.r2lDat    = $urandom;
            iSnkRdy       = ($urandom % 3) != 0;
            iClrCnt       = ($urandom % 64) == 0;
            rst           = ($urandom % 300) == 0;
            cycle();
        end
        rst = 1'b0; iClrCnt = 1'b0; iSrcVld = 1'b0; bus.l2rFul = 1'b0;

        // Ejection counter saturation
        bus.r2lPktVld = 1'b1; iSnkRdy = 1'b1;
        guard = 0;
        while (mEj < 16'hFFFE && guard < 70000) begin
            bus.r2lDat = 32'(guard);
            cycle();
            guard++;
        end
        if (mEj < 16'hFFFE) begin
            errors++;
            $display("FAIL sat_budget actual=%0d expected=65534", mEj);
        end
        repeat (3) cycle();
        #1 chk("sat_ej", 32'(oEjCnt), 32'hFFFF);
        iClrCnt = 1'b1;
        cycle();
        iClrCnt = 1'b0; bus.r2lPktVld = 1'b0; #1;
        chk("clr_wins", 32'(oEjCnt), 32'd0);
        repeat (3) cycle();

        // Reset mid-transfer with buffered words and a full egress register
        bus.l2rFul = 1'b1; bus.r2lPktVld = 1'b1; iSnkRdy = 1'b0;
        iSrcVld = 1'b1; iSrcDest = 3'd6;
        for (int i = 0; i < 2; i++) begin
            iSrcDat = 32'h3600 + 32'(i);
            cycle();
        end
        iSrcVld = 1'b0;
        #1 chk("pre_rst_vld", {31'd0, oSnkVld}, 32'd1);
        rst = 1'b1; #1;
        chk("mid_rst_out", {27'd0, oSrcRdy, oSnkVld, bus.l2rWr, bus.r2lRd, oErrDrop}, 32'd0);
        chk("mid_rst_cnt", {oInjCnt, oEjCnt}, 32'd0);
        repeat (2) cycle();
        rst = 1'b0; bus.l2rFul = 1'b0; bus.r2lPktVld = 1'b0; iSnkRdy = 1'b1;
        cycle(); #1;
        chk("post_rst_rdy", {31'd0, oSrcRdy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("post_rst_stale", {30'd0, oSnkVld, bus.l2rWr}, 32'd0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ptr_local_ni.md
PTR_LOCAL_NI -- requirements
Module: ptr_local_ni

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width; SHALL match the attached PtrNocLocalIf.
REQ-002 Parameter NODE_NUM, default 8, ring node count; DW = $clog2(NODE_NUM).
REQ-003 Parameter NODE_ID, default 0, this node's ring position, 0..NODE_NUM-1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 bLocalDat  PtrNocLocalIf.LocalNode  --  router local port (r2lPktVld, l2rFul, r2lDat in; r2lRd, l2rWr, l2rDat, destCnt out).
REQ-007 iSrcVld / oSrcRdy  in / out  1 / 1  ingress handshake.
REQ-008 iSrcDat / iSrcDest  in  DATA_WIDTH / DW  payload, absolute destination node.
REQ-009 oSnkVld / iSnkRdy  out / in  1 / 1  egress handshake.
REQ-010 oSnkDat / oSnkLoop  out  DATA_WIDTH / 1  egress payload; 1 = word came via local loopback.
REQ-011 oErrDrop  out  1  one-cycle pulse when an illegal destination is discarded.
REQ-012 iClrCnt  in  1  synchronous clear of statistics counters.
REQ-013 oInjCnt / oEjCnt  out  16 / 16  words injected to ring / delivered on egress.

Function
REQ-014 Ingress SHALL buffer words in a 2-entry FIFO; a word is accepted when iSrcVld & oSrcRdy; oSrcRdy = FIFO not full.
REQ-015 Head hop count SHALL be hop = (iSrcDest + NODE_NUM - NODE_ID) mod NODE_NUM, computed at DW+1 bits, then truncated to DW.
REQ-016 hop != 0: l2rWr = headValid & !l2rFul, l2rDat = head data, destCnt = hop; the head pops in the same cycle l2rWr is asserted.
REQ-017 hop == 0: the head SHALL NOT be written to the router; it SHALL be offered to the egress arbiter as a loopback request.
REQ-018 Head dest >= NODE_NUM: pop without l2rWr and pulse oErrDrop; no counter change.
REQ-019 Egress SHALL be a single output register; it loads when empty or when oSnkVld & iSnkRdy in the same cycle.
REQ-020 Egress sources are router (r2lPktVld) and loopback; when both request, round-robin on last grant; reset pointer favours router first.
REQ-021 r2lRd SHALL be asserted only in a cycle in which the output register loads the router word (r2lDat is first-word-fall-through).
REQ-022 Latency: router word appears on oSnk 1 cycle after r2lRd; loopback word appears 2 cycles after its ingress handshake, with no contention.
REQ-023 oSnkDat / oSnkLoop SHALL hold stable while oSnkVld & !iSnkRdy.
REQ-024 oInjCnt increments per l2rWr; oEjCnt increments per egress handshake; both saturate at 16'hFFFF.
REQ-025 iClrCnt SHALL win over a same-cycle increment (result 0).
REQ-026 Ring backpressure (l2rFul) SHALL stall only the ingress head; egress continues independently.

Reset
REQ-027 While rst is high, FIFO and egress register are empty; oSrcRdy, oSnkVld, l2rWr, r2lRd and oErrDrop are 0; counters are 0; RR pointer is reset.
REQ-028 oSrcRdy SHALL rise in the first cycle after rst deasserts; reset mid-transfer discards all buffered words.

Structure
REQ-029 Package ptr_noc_pkg SHALL hold the hop-count function and the STAT_W = 16 constant.
REQ-030 The ingress FIFO SHALL be an instance of TwoRegFifo, with WIDTH = DATA_WIDTH + DW.

Verification (NODE_NUM=8, NODE_ID=5)
REQ-031 Push dat=32'hA5A5_0001, dest=7 -> one l2rWr, destCnt=2, l2rDat=32'hA5A5_0001, oInjCnt=1.
REQ-032 Push dest=2 -> destCnt=5 (wrap); push dest=5 -> no l2rWr, oSnkVld with oSnkLoop=1 exactly 2 cycles after the handshake.
REQ-033 l2rFul=1 for 10 cycles with 3 pushes to dest=6 -> oSrcRdy low after 2 accepts, no l2rWr; on release, writes occur in order on consecutive cycles.
REQ-034 Continuous loopback and r2lPktVld with iSnkRdy=1 -> grants alternate R,L,R,L; with iSnkRdy=0 for 4 cycles -> oSnkDat stable and r2lRd=0.
REQ-035 Preload oEjCnt=16'hFFFE, deliver 3 words -> FFFF held; iClrCnt together with a handshake -> 0.
REQ-036 Assert rst with 2 words buffered and oSnkVld=1 -> all outputs 0 immediately; after release, oSrcRdy=1 and no stale word is emitted.
